// File: rtl/bram_multi_player.sv
// Windowed, decimated BRAM playback with repeat count, abort and a configurable
// read-latency pipeline; each BRAM word carries NCHAN parallel channel samples.
module bram_multi_player #(
    parameter int ADDR_WIDTH   = 10,
    parameter int NCHAN        = 2,
    parameter int CH_WIDTH     = 14,
    parameter int READ_LATENCY = 1,
    parameter int LOOP_WIDTH   = 16
) (
    input  logic                      axi_clock,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic [ADDR_WIDTH-1:0]     addr_start,
    input  logic [ADDR_WIDTH-1:0]     addr_end,
    input  logic [31:0]               dec_rate,
    input  logic [LOOP_WIDTH-1:0]     n_loops,
    input  logic [NCHAN*CH_WIDTH-1:0] default_value,
    output logic [ADDR_WIDTH-1:0]     bram_addr,
    output logic                      bram_en,
    input  logic [NCHAN*CH_WIDTH-1:0] bram_data,
    output logic [NCHAN*CH_WIDTH-1:0] dout,
    output logic                      dout_valid,
    output logic                      busy,
    output logic                      finish,
    output logic [LOOP_WIDTH-1:0]     loop_count
);
    localparam int DW = NCHAN * CH_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    start_prev_q;
    logic [ADDR_WIDTH-1:0]   addr_start_q, addr_start_d;
    logic [ADDR_WIDTH-1:0]   addr_end_q, addr_end_d;
    logic [31:0]             dec_q, dec_d;
    logic [LOOP_WIDTH-1:0]   n_loops_q, n_loops_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   bram_addr_q, bram_addr_d;
    logic                    bram_en_q, bram_en_d;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;
    logic [DW-1:0]           dout_q, dout_d;
    logic                    dout_valid_q, dout_valid_d;
    logic                    busy_q, busy_d;
    logic                    finish_q, finish_d;
    logic [LOOP_WIDTH-1:0]   loop_count_q, loop_count_d;

    logic                    start_edge;
    logic                    abort;
    logic                    do_issue;
    logic [ADDR_WIDTH-1:0]   iss_addr;
    logic [ADDR_WIDTH-1:0]   win_start;
    logic [ADDR_WIDTH-1:0]   win_end;
    logic [LOOP_WIDTH-1:0]   win_loops;
    logic [31:0]             win_dec;
    logic [LOOP_WIDTH-1:0]   lc_base;
    logic [LOOP_WIDTH-1:0]   lc_inc;

    assign start_edge = start & ~start_prev_q;
    assign abort      = stop && (state_q != ST_IDLE);

    // Valid pipeline mirrors the BRAM read latency; abort empties it in one cycle.
    assign pipe_d[0] = bram_en_q & ~abort;
    generate
        for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_pipe
            assign pipe_d[gi] = pipe_q[gi-1] & ~abort;
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        addr_start_d = addr_start_q;
        addr_end_d   = addr_end_q;
        dec_d        = dec_q;
        n_loops_d    = n_loops_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        bram_addr_d  = bram_addr_q;
        bram_en_d    = 1'b0;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        finish_d     = 1'b0;
        loop_count_d = loop_count_q;

        do_issue  = 1'b0;
        iss_addr  = addr_q;
        win_start = addr_start_q;
        win_end   = addr_end_q;
        win_loops = n_loops_q;
        win_dec   = dec_q;
        lc_base   = loop_count_q;
        lc_inc    = '0;

        case (state_q)
            ST_IDLE: begin
                dout_d = default_value;
                if (start_edge && !stop) begin
                    // The first issue uses the live inputs so it lands one cycle after the edge.
                    do_issue     = 1'b1;
                    iss_addr     = addr_start;
                    win_start    = addr_start;
                    win_end      = addr_end;
                    win_loops    = n_loops;
                    win_dec      = dec_rate;
                    lc_base      = '0;
                    addr_start_d = addr_start;
                    addr_end_d   = addr_end;
                    dec_d        = dec_rate;
                    n_loops_d    = n_loops;
                    loop_count_d = '0;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pipe_q[READ_LATENCY-1]) begin
                    dout_d       = bram_data;
                    dout_valid_d = 1'b1;
                end
                if (cnt_q == 32'd0) begin
                    do_issue = 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_DRAIN: begin
                if (pipe_q[READ_LATENCY-1]) begin
                    dout_d       = bram_data;
                    dout_valid_d = 1'b1;
                end
                if (!bram_en_q && (pipe_q == '0)) begin
                    state_d  = ST_IDLE;
                    finish_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_issue) begin
            bram_en_d   = 1'b1;
            bram_addr_d = iss_addr;
            cnt_d       = (win_dec > 32'd1) ? (win_dec - 32'd1) : 32'd0;
            if (iss_addr == win_end) begin
                lc_inc       = (lc_base == '1) ? lc_base : (lc_base + LOOP_WIDTH'(1));
                loop_count_d = lc_inc;
                addr_d       = win_start;
                if ((win_loops != '0) && (lc_inc >= win_loops)) begin
                    state_d = ST_DRAIN;
                end
            end else begin
                addr_d = iss_addr + ADDR_WIDTH'(1);
            end
        end

        if (abort) begin
            state_d      = ST_IDLE;
            bram_en_d    = 1'b0;
            dout_d       = default_value;
            dout_valid_d = 1'b0;
            finish_d     = 1'b0;
            loop_count_d = loop_count_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge axi_clock or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            addr_start_q <= '0;
            addr_end_q   <= '0;
            dec_q        <= '0;
            n_loops_q    <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            bram_addr_q  <= '0;
            bram_en_q    <= 1'b0;
            pipe_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            finish_q     <= 1'b0;
            loop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start;
            addr_start_q <= addr_start_d;
            addr_end_q   <= addr_end_d;
            dec_q        <= dec_d;
            n_loops_q    <= n_loops_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            bram_addr_q  <= bram_addr_d;
            bram_en_q    <= bram_en_d;
            pipe_q       <= pipe_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            finish_q     <= finish_d;
            loop_count_q <= loop_count_d;
        end
    end

    assign bram_addr  = bram_addr_q;
    assign bram_en    = bram_en_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign finish     = finish_q;
    assign loop_count = loop_count_q;

endmodule
